// File: rtl/spi_sched_pkg.sv
// Shared definitions for the SPI request scheduler.
// Holds the FSM state encoding, the default timing constants (in clock cycles
// at 20 kHz), and datapath widths. CNT_W = 16 covers the largest timer
// (40000 cycles).
package spi_sched_pkg;

    localparam int CNT_W   = 16;
    localparam int TEMP_W  = 10;
    localparam int RETRY_W = 4;

    localparam int DEF_START_DELAY   = 3000;
    localparam int DEF_TEMP_PERIOD   = 20000;
    localparam int DEF_THERM_TIMEOUT = 2000;
    localparam int DEF_PROG_TIMEOUT  = 40000;
    localparam int DEF_BACKOFF       = 200;
    localparam int DEF_MAX_RETRY     = 3;

    typedef enum logic [2:0] {
        ST_STARTUP   = 3'd0,
        ST_IDLE      = 3'd1,
        ST_REQ_PROG  = 3'd2,
        ST_REL_PROG  = 3'd3,
        ST_REQ_THERM = 3'd4,
        ST_REL_THERM = 3'd5,
        ST_BACKOFF   = 3'd6
    } state_t;

    // Down counters terminate at zero, so an N-cycle interval preloads N-1.
    function automatic logic [CNT_W-1:0] cnt_preset(input int cycles);
        return CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/spi_request_scheduler_if.sv
// Request/ready handshake between the scheduler and the SPI handler.
// Signal names are from the scheduler's point of view.
//   master (scheduler): drives o_read_program, o_read_therm;
//                       receives i_program_ready, i_therm_ready, i_temperature
//   slave  (handler)  : the mirror image
interface spi_request_scheduler_if;
    logic                             o_read_program;
    logic                             i_program_ready;
    logic                             o_read_therm;
    logic                             i_therm_ready;
    logic [spi_sched_pkg::TEMP_W-1:0] i_temperature;

    modport master (
        output o_read_program, o_read_therm,
        input  i_program_ready, i_therm_ready, i_temperature
    );

    modport slave (
        input  o_read_program, o_read_therm,
        output i_program_ready, i_therm_ready, i_temperature
    );
endinterface

// File: rtl/sched_down_counter.sv
// Loadable down counter with auto-reload.
//   i_clk, i_reset_n : clock, synchronous active-low reset (loads i_rst_val)
//   i_load           : load i_load_val (wins over i_en)
//   i_en             : count down one step
//   o_tc             : high for the enabled cycle in which the count is zero;
//                      the counter then reloads i_load_val, giving a period of
//                      i_load_val+1 enabled cycles
module sched_down_counter
    import spi_sched_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic [CNT_W-1:0] i_rst_val,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_tc
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Terminal count does not depend on i_load, so the load input can be
    // derived from next-state logic that itself consumes o_tc.
    assign o_tc = i_en && (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (i_load)
            cnt_d = i_load_val;
        else if (i_en)
            cnt_d = (cnt_q == '0) ? i_load_val : cnt_q - CNT_W'(1);
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) cnt_q <= i_rst_val;
        else            cnt_q <= cnt_d;
    end
endmodule

// File: rtl/spi_request_scheduler.sv
// Sequences the SPI handler: a boot program load, periodic temperature
// reads, program reloads on request, timeout with backoff/retry, and fault
// reporting. One transaction at a time over a level-held request/ready
// handshake.
//   i_clk, i_reset_n  : 20 kHz clock, synchronous active-low reset
//   i_program_update  : pulse, request a program reload
//   i_spi_disconnect  : bus unavailable; no launch, timeouts frozen
//   spi (master)      : read_program/program_ready, read_therm/therm_ready,
//                       temperature
//   o_temperature     : last good temperature, o_temp_valid sticky
//   o_temp_update     : pulse, o_temperature updated
//   o_program_load    : pulse, program data present on the handler
//   o_busy            : not in IDLE/STARTUP
//   o_fault           : MAX_RETRY consecutive timeouts, cleared on success
module spi_request_scheduler
    import spi_sched_pkg::*;
#(
    parameter int START_DELAY   = DEF_START_DELAY,
    parameter int TEMP_PERIOD   = DEF_TEMP_PERIOD,
    parameter int THERM_TIMEOUT = DEF_THERM_TIMEOUT,
    parameter int PROG_TIMEOUT  = DEF_PROG_TIMEOUT,
    parameter int BACKOFF       = DEF_BACKOFF,
    parameter int MAX_RETRY     = DEF_MAX_RETRY
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    input  logic                    i_program_update,
    input  logic                    i_spi_disconnect,
    spi_request_scheduler_if.master spi,
    output logic [TEMP_W-1:0]       o_temperature,
    output logic                    o_temp_valid,
    output logic                    o_temp_update,
    output logic                    o_program_load,
    output logic                    o_busy,
    output logic                    o_fault
);
    localparam logic [CNT_W-1:0]   START_V    = cnt_preset(START_DELAY);
    localparam logic [CNT_W-1:0]   PERIOD_V   = cnt_preset(TEMP_PERIOD);
    localparam logic [CNT_W-1:0]   THERM_TO_V = cnt_preset(THERM_TIMEOUT);
    localparam logic [CNT_W-1:0]   PROG_TO_V  = cnt_preset(PROG_TIMEOUT);
    localparam logic [CNT_W-1:0]   BACKOFF_V  = cnt_preset(BACKOFF);
    localparam logic [RETRY_W-1:0] LAST_TRY   = RETRY_W'(MAX_RETRY - 1);

    state_t              state_q, state_d;
    logic                rd_prog_q, rd_prog_d, rd_therm_q, rd_therm_d;
    logic [TEMP_W-1:0]   temp_q, temp_d;
    logic                valid_q, valid_d, upd_q, upd_d, load_q, load_d;
    logic                busy_q, busy_d, fault_q, fault_d;
    logic [RETRY_W-1:0]  retry_q, retry_d;
    logic                prog_pend_q, prog_pend_d, therm_pend_q, therm_pend_d;

    logic                timed_out, give_up, prog_phase;
    logic                per_tc, dly_tc, to_tc;
    logic                dly_load, dly_en, to_load, to_en;
    logic [CNT_W-1:0]    to_load_val;

    // Period timer: held preloaded during STARTUP, free-running afterwards.
    sched_down_counter u_period (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_rst_val(PERIOD_V),
        .i_load(state_q == ST_STARTUP), .i_load_val(PERIOD_V),
        .i_en(state_q != ST_STARTUP), .o_tc(per_tc)
    );

    // Startup delay and retry backoff share one timer; reset preloads the
    // startup interval, entry to BACKOFF loads the backoff interval.
    assign dly_load = (state_d == ST_BACKOFF) && (state_q != ST_BACKOFF);
    assign dly_en   = (state_q == ST_STARTUP) || (state_q == ST_BACKOFF);

    sched_down_counter u_delay (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_rst_val(START_V),
        .i_load(dly_load), .i_load_val(BACKOFF_V),
        .i_en(dly_en), .o_tc(dly_tc)
    );

    // Transaction timeout: restarted on every REQ/REL entry, frozen while
    // the bus is disconnected so the handler can recover in place.
    assign to_load     = (state_d != state_q) &&
                         (state_d inside {ST_REQ_PROG, ST_REL_PROG, ST_REQ_THERM, ST_REL_THERM});
    assign to_load_val = (state_d inside {ST_REQ_PROG, ST_REL_PROG}) ? PROG_TO_V : THERM_TO_V;
    assign to_en       = (state_q inside {ST_REQ_PROG, ST_REL_PROG, ST_REQ_THERM, ST_REL_THERM}) &&
                         !i_spi_disconnect;

    sched_down_counter u_timeout (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_rst_val('0),
        .i_load(to_load), .i_load_val(to_load_val),
        .i_en(to_en), .o_tc(to_tc)
    );

    assign prog_phase = (state_q == ST_REQ_PROG) || (state_q == ST_REL_PROG);
    assign give_up    = timed_out && (retry_q == LAST_TRY);

    always_comb begin
        state_d      = state_q;
        rd_prog_d    = 1'b0;
        rd_therm_d   = 1'b0;
        temp_d       = temp_q;
        valid_d      = valid_q;
        upd_d        = 1'b0;
        load_d       = 1'b0;
        fault_d      = fault_q;
        retry_d      = retry_q;
        prog_pend_d  = prog_pend_q;
        therm_pend_d = therm_pend_q;
        timed_out    = 1'b0;

        unique case (state_q)
            ST_STARTUP: if (dly_tc) state_d = ST_IDLE;
            ST_IDLE: begin
                if (!i_spi_disconnect) begin
                    if (prog_pend_q) begin
                        state_d     = ST_REQ_PROG;
                        rd_prog_d   = 1'b1;
                        prog_pend_d = 1'b0;
                    end else if (therm_pend_q) begin
                        state_d      = ST_REQ_THERM;
                        rd_therm_d   = 1'b1;
                        therm_pend_d = 1'b0;
                    end
                end
            end
            // Ready is checked before the timeout so it wins a tie.
            ST_REQ_PROG: begin
                if (spi.i_program_ready) begin
                    load_d  = 1'b1;
                    retry_d = '0;
                    fault_d = 1'b0;
                    state_d = ST_REL_PROG;
                end else if (to_tc) begin
                    timed_out = 1'b1;
                end else begin
                    rd_prog_d = 1'b1;
                end
            end
            ST_REL_PROG: begin
                if (!spi.i_program_ready) state_d = ST_IDLE;
                else if (to_tc)           timed_out = 1'b1;
            end
            ST_REQ_THERM: begin
                if (spi.i_therm_ready) begin
                    temp_d  = spi.i_temperature;
                    valid_d = 1'b1;
                    upd_d   = 1'b1;
                    retry_d = '0;
                    fault_d = 1'b0;
                    state_d = ST_REL_THERM;
                end else if (to_tc) begin
                    timed_out = 1'b1;
                end else begin
                    rd_therm_d = 1'b1;
                end
            end
            ST_REL_THERM: begin
                if (!spi.i_therm_ready) state_d = ST_IDLE;
                else if (to_tc)         timed_out = 1'b1;
            end
            ST_BACKOFF: if (dly_tc) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase

        // A timeout re-arms its request type for normal arbitration; the
        // last allowed attempt instead raises the fault and drops the request.
        if (timed_out) begin
            state_d = ST_BACKOFF;
            retry_d = give_up ? '0 : retry_q + RETRY_W'(1);
            if (give_up)    fault_d      = 1'b1;
            if (prog_phase) prog_pend_d  = !give_up;
            else            therm_pend_d = !give_up;
        end

        // External triggers are set-dominant over same-cycle clears.
        prog_pend_d  = prog_pend_d  | i_program_update;
        therm_pend_d = therm_pend_d | per_tc;

        busy_d = !(state_d inside {ST_IDLE, ST_STARTUP});
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q      <= ST_STARTUP;
            rd_prog_q    <= 1'b0;
            rd_therm_q   <= 1'b0;
            temp_q       <= '0;
            valid_q      <= 1'b0;
            upd_q        <= 1'b0;
            load_q       <= 1'b0;
            busy_q       <= 1'b0;
            fault_q      <= 1'b0;
            retry_q      <= '0;
            prog_pend_q  <= 1'b1;
            therm_pend_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            rd_prog_q    <= rd_prog_d;
            rd_therm_q   <= rd_therm_d;
            temp_q       <= temp_d;
            valid_q      <= valid_d;
            upd_q        <= upd_d;
            load_q       <= load_d;
            busy_q       <= busy_d;
            fault_q      <= fault_d;
            retry_q      <= retry_d;
            prog_pend_q  <= prog_pend_d;
            therm_pend_q <= therm_pend_d;
        end
    end

    assign spi.o_read_program = rd_prog_q;
    assign spi.o_read_therm   = rd_therm_q;
    assign o_temperature      = temp_q;
    assign o_temp_valid       = valid_q;
    assign o_temp_update      = upd_q;
    assign o_program_load     = load_q;
    assign o_busy             = busy_q;
    assign o_fault            = fault_q;
endmodule
